// File: rtl/vmem_pkg.sv
// Shared constants and owner encoding for the video-memory arbiter.
package vmem_pkg;

   localparam int unsigned VMEM_AW         = 14;
   localparam int unsigned VMEM_DW         = 12;
   localparam int unsigned VMEM_FAIR_LIMIT = 64;
   localparam int unsigned VMEM_CNT_W      = 7;

   // Who owns the RAM read data arriving in the following cycle.
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_VID    = 2'd1,
      OWN_CPU_RD = 2'd2
   } own_t;

endpackage

// File: rtl/vmem_fair_counter.sv
// Counts consecutive denied CPU cycles and raises a one-cycle force once the
// configured limit is reached; a limit of 0 never forces.
module vmem_fair_counter
   import vmem_pkg::*;
#(
   parameter int unsigned CNT_W      = VMEM_CNT_W,
   parameter int unsigned FAIR_LIMIT = VMEM_FAIR_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic grant_cpu,
   output logic force_cpu
);

   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(FAIR_LIMIT);
   localparam bit               FORCE_EN = (FAIR_LIMIT != 0);

   logic [CNT_W-1:0] wait_cnt;

   // Saturates instead of wrapping so a disabled limit cannot alias to a force.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!cpu_req || grant_cpu) begin
         wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      force_cpu = FORCE_EN && (wait_cnt >= LIMIT);
   end

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port video RAM arbiter: video has priority, the CPU takes idle cycles
// and a forced slot after a bounded wait; reads return one cycle after grant.
module vmem_arbiter
   import vmem_pkg::*;
#(
   parameter int unsigned AW         = VMEM_AW,
   parameter int unsigned DW         = VMEM_DW,
   parameter int unsigned FAIR_LIMIT = VMEM_FAIR_LIMIT,
   parameter int unsigned CNT_W      = VMEM_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          video_req,
   input  logic [AW-1:0] video_addr,
   output logic [DW-1:0] video_rdata,
   output logic          video_rvalid,
   output logic          video_miss,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_q
);

   logic          grant_cpu;
   logic          grant_vid;
   logic          force_cpu;
   own_t          own;
   own_t          own_next;
   logic [DW-1:0] vid_hold;
   logic [DW-1:0] cpu_hold;

   vmem_fair_counter #(
      .CNT_W      (CNT_W),
      .FAIR_LIMIT (FAIR_LIMIT)
   ) u_fair (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .grant_cpu (grant_cpu),
      .force_cpu (force_cpu)
   );

   // Grants are masked by rst so the RAM never sees a write while in reset.
   always_comb begin
      grant_cpu = !rst && cpu_req && (!video_req || force_cpu);
      grant_vid = !rst && video_req && !grant_cpu;
      cpu_ack   = grant_cpu;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      own_next  = OWN_NONE;
      if (grant_cpu) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
         own_next  = cpu_we ? OWN_NONE : OWN_CPU_RD;
      end else if (grant_vid) begin
         mem_addr = video_addr;
         own_next = OWN_VID;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own        <= OWN_NONE;
         video_miss <= 1'b0;
         vid_hold   <= '0;
         cpu_hold   <= '0;
      end else begin
         own        <= own_next;
         video_miss <= video_req && grant_cpu;
         if (own == OWN_VID) begin
            vid_hold <= mem_q;
         end
         if (own == OWN_CPU_RD) begin
            cpu_hold <= mem_q;
         end
      end
   end

   // Read data passes mem_q straight through in its valid cycle, else holds.
   always_comb begin
      video_rvalid = (own == OWN_VID);
      cpu_rvalid   = (own == OWN_CPU_RD);
      video_rdata  = video_rvalid ? mem_q : vid_hold;
      cpu_rdata    = cpu_rvalid ? mem_q : cpu_hold;
   end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model; a second instance runs with forcing disabled.
module tb_vmem_arbiter;

   localparam int unsigned AW  = 14;
   localparam int unsigned DW  = 12;
   localparam int          LIM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          video_req = 1'b0;
   logic [AW-1:0] video_addr = '0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;

   logic [DW-1:0] v_rdata, c_rdata, m_wdata, m_q;
   logic          v_rvalid, v_miss, c_ack, c_rvalid, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] v_rdata0, c_rdata0, m_wdata0, m_q0;
   logic          v_rvalid0, v_miss0, c_ack0, c_rvalid0, m_we0;
   logic [AW-1:0] m_addr0;

   logic [DW-1:0] ram     [0:(1<<AW)-1];
   logic [DW-1:0] ram0    [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   int   checks = 0;
   int   errors = 0;
   int   waited = 0;
   logic e_vvalid = 1'b0, e_cvalid = 1'b0, e_miss = 1'b0;
   logic [DW-1:0] e_vdata = '0, e_cdata = '0;
   logic g_cpu, g_vid, seen_ack, seen_ack0;

   always #5 clk = ~clk;

   vmem_arbiter #(.AW(AW), .DW(DW), .FAIR_LIMIT(LIM), .CNT_W(7)) dut (
      .clk(clk), .rst(rst),
      .video_req(video_req), .video_addr(video_addr), .video_rdata(v_rdata),
      .video_rvalid(v_rvalid), .video_miss(v_miss),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(c_ack), .cpu_rdata(c_rdata), .cpu_rvalid(c_rvalid),
      .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_we(m_we), .mem_q(m_q)
   );

   vmem_arbiter #(.AW(AW), .DW(DW), .FAIR_LIMIT(0), .CNT_W(7)) dut0 (
      .clk(clk), .rst(rst),
      .video_req(video_req), .video_addr(video_addr), .video_rdata(v_rdata0),
      .video_rvalid(v_rvalid0), .video_miss(v_miss0),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(c_ack0), .cpu_rdata(c_rdata0), .cpu_rvalid(c_rvalid0),
      .mem_addr(m_addr0), .mem_wdata(m_wdata0), .mem_we(m_we0), .mem_q(m_q0)
   );

   always @(posedge clk) begin
      if (m_we) ram[m_addr] <= m_wdata;
      m_q <= ram[m_addr];
      if (m_we0) ram0[m_addr0] <= m_wdata0;
      m_q0 <= ram0[m_addr0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic step();
      @(negedge clk);
      if (rst) begin
         e_vvalid = 1'b0; e_cvalid = 1'b0; e_miss = 1'b0;
         e_vdata = '0; e_cdata = '0; waited = 0;
      end
      g_cpu = !rst && cpu_req && (!video_req || (waited >= LIM));
      g_vid = !rst && video_req && !g_cpu;
      seen_ack  = c_ack;
      seen_ack0 = c_ack0;
      chk("cpu_ack", c_ack, g_cpu);
      chk("mem_we", m_we, g_cpu && cpu_we);
      chk("mem_addr", m_addr, g_cpu ? cpu_addr : (g_vid ? video_addr : '0));
      if (g_cpu && cpu_we) chk("mem_wdata", m_wdata, cpu_wdata);
      chk("video_rvalid", v_rvalid, e_vvalid);
      chk("video_rdata", v_rdata, e_vdata);
      chk("cpu_rvalid", c_rvalid, e_cvalid);
      chk("cpu_rdata", c_rdata, e_cdata);
      chk("video_miss", v_miss, e_miss);
      chk("nf_cpu_ack", c_ack0, !rst && cpu_req && !video_req);
      chk("nf_mem_we", m_we0, !rst && cpu_req && !video_req && cpu_we);
      chk("nf_video_miss", v_miss0, 1'b0);
      @(posedge clk);
      if (!rst) begin
         e_vvalid = g_vid;
         if (g_vid) e_vdata = ref_mem[video_addr];
         e_cvalid = g_cpu && !cpu_we;
         if (e_cvalid) e_cdata = ref_mem[cpu_addr];
         if (g_cpu && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
         e_miss = video_req && g_cpu;
         waited = (cpu_req && !g_cpu) ? waited + 1 : 0;
      end
      #1;
   endtask

   initial begin
      logic [DW-1:0] t1_exp [0:3];
      int ack_cyc;
      int acks0;
      bit pend;

      t1_exp[0] = 12'hA5A; t1_exp[1] = 12'hA5B; t1_exp[2] = 12'hA58; t1_exp[3] = 12'hA59;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]     = DW'(i) ^ 12'hA5A;
         ram0[i]    = DW'(i) ^ 12'hA5A;
         ref_mem[i] = DW'(i) ^ 12'hA5A;
      end

      // Reset state
      step();
      rst = 1'b0;
      chk("reset_video_rvalid", v_rvalid, 1'b0);
      chk("reset_cpu_rdata", c_rdata, '0);

      // Video-only reads of 0..3
      for (int i = 0; i < 5; i++) begin
         video_req  = (i < 4);
         video_addr = AW'(i);
         step();
         if (i < 4) begin
            chk("t1_video_rvalid", v_rvalid, 1'b1);
            chk("t1_video_rdata", v_rdata, t1_exp[i]);
         end
      end

      // CPU write then read-back of the same address
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 12'h7FF;
      step();
      cpu_we = 1'b0;
      step();
      cpu_req = 1'b0;
      chk("t2_cpu_rvalid", c_rvalid, 1'b1);
      chk("t2_cpu_rdata", c_rdata, 12'h7FF);
      step();

      // Starvation with forcing after LIM denied cycles
      ack_cyc = 0;
      video_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         video_addr = AW'($urandom_range(0, 255));
         step();
         if (seen_ack) begin
            if (ack_cyc == 0) ack_cyc = cyc;
            cpu_req = 1'b0;
         end
         chk("t4_video_rvalid", v_rvalid, (cyc != 5));
         if (cyc == 5) begin
            chk("t4_video_miss", v_miss, 1'b1);
            chk("t4_cpu_rvalid", c_rvalid, 1'b1);
            chk("t4_cpu_rdata", c_rdata, 12'hA4A);
         end
      end
      chk("t4_ack_cycle", ack_cyc, 5);
      video_req = 1'b0; cpu_req = 1'b0;
      step();

      // Contention without forcing: the no-force instance waits for video to drop
      acks0 = 0;
      video_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
      for (int cyc = 0; cyc < 10; cyc++) begin
         video_addr = AW'($urandom_range(0, 255));
         step();
         if (seen_ack0) acks0++;
      end
      chk("t3_nf_acks_during_video", acks0, 0);
      video_req = 1'b0;
      step();
      chk("t3_nf_ack_after_video", seen_ack0, 1'b1);
      cpu_req = 1'b0;
      step();

      // Forcing disabled: counter saturates rather than wrapping
      acks0 = 0;
      video_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040;
      for (int cyc = 0; cyc < 200; cyc++) begin
         video_addr = AW'($urandom_range(0, 255));
         step();
         if (seen_ack0) acks0++;
      end
      chk("t5_nf_acks", acks0, 0);
      chk("t5_nf_wait_cnt", dut0.u_fair.wait_cnt, 127);
      video_req = 1'b0; cpu_req = 1'b0;
      step();

      // Reset between a CPU read grant and its data cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0030;
      step();
      rst = 1'b1;
      cpu_we = 1'b1; cpu_addr = 14'h0031; cpu_wdata = 12'h123;
      #1;
      chk("t6_cpu_rvalid_async", c_rvalid, 1'b0);
      chk("t6_cpu_rdata_async", c_rdata, '0);
      step();
      step();
      rst = 1'b0;
      step();
      cpu_we = 1'b0;
      step();
      cpu_req = 1'b0;
      chk("t6_readback_rvalid", c_rvalid, 1'b1);
      chk("t6_readback_rdata", c_rdata, 12'h123);
      step();

      // Random traffic, CPU protocol honoured (hold until ack)
      pend = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (!pend || seen_ack) begin
            if ($urandom_range(0, 2) != 0) begin
               cpu_req   = 1'b1;
               cpu_we    = 1'($urandom_range(0, 1));
               cpu_addr  = AW'($urandom_range(0, 31));
               cpu_wdata = DW'($urandom);
               pend      = 1'b1;
            end else begin
               cpu_req = 1'b0;
               pend    = 1'b0;
            end
         end
         video_req  = ($urandom_range(0, 9) < 7);
         video_addr = AW'($urandom_range(0, 31));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
